es8psk_deframer: RTL

//  Sits directly downstream of the ES-8PSK demodulator; consumes its 3-bit Gray-mapped symbol stream.

---
 rtl/es8psk_deframer_pkg.sv | 28 ++
 rtl/es8psk_deframer_if.sv | 14 +
 rtl/es8psk_deframer_byte_fifo.sv | 53 +++++
 rtl/es8psk_deframer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/es8psk_deframer_pkg.sv
// Shared definitions for the ES-8PSK deframer: symbol width, FSM states,
// default sync word and the Gray symbol map shared with the demodulator.
package es8psk_deframer_pkg;

   localparam int SYM_W = 3;

   // Default sync word, first-received symbol in the top three bits.
   localparam logic [23:0] DEF_SYNC_WORD = 24'o70722701;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HUNT    = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_e;

   // Gray mapping of constellation phase index to symbol value.
   typedef enum logic [SYM_W-1:0] {
      GRAY_PH0 = 3'b000,
      GRAY_PH1 = 3'b001,
      GRAY_PH2 = 3'b011,
      GRAY_PH3 = 3'b010,
      GRAY_PH4 = 3'b110,
      GRAY_PH5 = 3'b111,
      GRAY_PH6 = 3'b101,
      GRAY_PH7 = 3'b100
   } gray_sym_e;

endpackage

// File: rtl/es8psk_deframer_if.sv
// Byte stream from the deframer FIFO to the MAC/packet layer.
//   byte_data  8  FIFO head byte
//   byte_valid 1  byte_data valid
//   byte_last  1  last byte of its frame
//   byte_ready 1  sink accepts; transfer on byte_valid & byte_ready
interface es8psk_deframer_if;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_last;
   logic       byte_ready;

   modport master (output byte_data, output byte_valid, output byte_last, input  byte_ready);
   modport slave  (input  byte_data, input  byte_valid, input  byte_last, output byte_ready);
endinterface

// File: rtl/es8psk_deframer_byte_fifo.sv
// Synchronous FIFO for completed bytes (data + last flag).
//   clk, reset_b    clock, synchronous active-low reset
//   push, wdata     write request and entry
//   pop             read request (ignored when empty)
//   rdata           head entry, zero while empty
//   empty, full     occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module es8psk_deframer_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/es8psk_deframer.sv
// ES-8PSK deframer: hunts for the sync word in the demodulated symbol stream,
// packs the payload MSB-first into bytes and queues them for a valid/ready sink.
//   clk, reset_b    clock, synchronous active-low reset
//   ena_in          receiver enable; low forces IDLE
//   sym_in, sym_vld demodulated symbol and its single-cycle strobe
//   byte_if         byte stream master (data/valid/last out, ready in)
//   sync_found      pulse: sync accepted
//   frame_abort     pulse: enable dropped during payload
//   overflow        pulse: completed byte dropped on a full FIFO
//
// state   | meaning
// IDLE    | receiver disabled, hunt/packer state held clear
// HUNT    | shifting symbols, comparing against the sync word
// PAYLOAD | packing symbols into bytes until the frame length is reached
module es8psk_deframer
   import es8psk_deframer_pkg::*;
#(
   parameter int                        SYNC_LEN      = 8,
   parameter logic [SYNC_LEN*SYM_W-1:0] SYNC_WORD     = DEF_SYNC_WORD,
   parameter int                        MAX_SYM_ERR   = 0,
   parameter int                        PAYLOAD_BYTES = 64,
   parameter int                        FIFO_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset_b,
   input  logic               ena_in,
   input  logic [SYM_W-1:0]   sym_in,
   input  logic               sym_vld,
   es8psk_deframer_if.master  byte_if,
   output logic               sync_found,
   output logic               frame_abort,
   output logic               overflow
);

   localparam int SR_W   = SYNC_LEN * SYM_W;
   localparam int FILL_W = $clog2(SYNC_LEN + 1);

   state_e            state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d, sr_shift;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [6:0]        bit_buf_q, bit_buf_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [11:0]       byte_cnt_q, byte_cnt_d;
   logic [7:0]        pend_byte_q, pend_byte_d;
   logic              pend_last_q, pend_last_d;
   logic              pend_push_q, pend_push_d;
   logic              sync_found_d, frame_abort_d;

   logic [4:0]        err_cnt;
   logic              fill_done, sync_match;
   logic [9:0]        pk_cat;
   logic [3:0]        pk_cnt;
   logic [2:0]        pk_rem_cnt;
   logic              pk_done, pk_last;
   logic [7:0]        pk_byte;
   logic [6:0]        pk_rem;

   logic [8:0]        fifo_rdata;
   logic              fifo_empty, fifo_full, fifo_pop;

   // Compare the window as it will look once this cycle's symbol is shifted in.
   assign sr_shift  = SR_W'({sr_q, sym_in});
   assign fill_done = (fill_q >= FILL_W'(SYNC_LEN - 1));

   always_comb begin
      err_cnt = '0;
      for (int i = 0; i < SYNC_LEN; i++) begin
         if (sr_shift[i*SYM_W +: SYM_W] != SYNC_WORD[i*SYM_W +: SYM_W]) err_cnt = err_cnt + 5'd1;
      end
   end

   assign sync_match = fill_done && (err_cnt <= 5'(MAX_SYM_ERR));

   // Packer keeps at most 7 leftover bits LSB-aligned; a new symbol makes 3..10.
   assign pk_cat     = {bit_buf_q, sym_in};
   assign pk_cnt     = {1'b0, bit_cnt_q} + 4'd3;
   assign pk_done    = (pk_cnt >= 4'd8);
   assign pk_rem_cnt = 3'(pk_cnt - 4'd8);
   assign pk_byte    = 8'(pk_cat >> pk_rem_cnt);
   assign pk_rem     = 7'(pk_cat & ((10'd1 << pk_rem_cnt) - 10'd1));
   assign pk_last    = (byte_cnt_q == 12'(PAYLOAD_BYTES - 1));

   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      fill_d        = fill_q;
      bit_buf_d     = bit_buf_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      pend_byte_d   = pend_byte_q;
      pend_last_d   = pend_last_q;
      pend_push_d   = 1'b0;
      sync_found_d  = 1'b0;
      frame_abort_d = 1'b0;
      if (!ena_in) begin
         state_d       = ST_IDLE;
         frame_abort_d = (state_q == ST_PAYLOAD);
         sr_d          = '0;
         fill_d        = '0;
         bit_buf_d     = '0;
         bit_cnt_d     = '0;
         byte_cnt_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_HUNT;
               sr_d    = '0;
               fill_d  = '0;
            end
            ST_HUNT: begin
               if (sym_vld) begin
                  sr_d   = sr_shift;
                  fill_d = fill_done ? FILL_W'(SYNC_LEN) : fill_q + FILL_W'(1);
                  if (sync_match) begin
                     state_d      = ST_PAYLOAD;
                     sync_found_d = 1'b1;
                     bit_buf_d    = '0;
                     bit_cnt_d    = '0;
                     byte_cnt_d   = '0;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (sym_vld) begin
                  if (pk_done) begin
                     pend_push_d = 1'b1;
                     pend_byte_d = pk_byte;
                     pend_last_d = pk_last;
                     byte_cnt_d  = byte_cnt_q + 12'd1;
                     bit_buf_d   = pk_rem;
                     bit_cnt_d   = pk_rem_cnt;
                     if (pk_last) begin
                        // Leftover bits and the completing symbol are not reused for sync.
                        state_d    = ST_HUNT;
                        sr_d       = '0;
                        fill_d     = '0;
                        bit_buf_d  = '0;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                     end
                  end else begin
                     bit_buf_d = pk_cat[6:0];
                     bit_cnt_d = pk_cnt[2:0];
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         fill_q      <= '0;
         bit_buf_q   <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         pend_byte_q <= '0;
         pend_last_q <= 1'b0;
         pend_push_q <= 1'b0;
         sync_found  <= 1'b0;
         frame_abort <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         bit_buf_q   <= bit_buf_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         pend_byte_q <= pend_byte_d;
         pend_last_q <= pend_last_d;
         pend_push_q <= pend_push_d;
         sync_found  <= sync_found_d;
         frame_abort <= frame_abort_d;
         overflow    <= pend_push_q && fifo_full && !fifo_pop;
      end
   end

   // Completed bytes are staged one cycle before entering the FIFO.
   es8psk_deframer_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk     (clk),
      .reset_b (reset_b),
      .push    (pend_push_q),
      .wdata   ({pend_last_q, pend_byte_q}),
      .pop     (fifo_pop),
      .rdata   (fifo_rdata),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign fifo_pop           = byte_if.byte_valid && byte_if.byte_ready;
   assign byte_if.byte_valid = !fifo_empty;
   assign byte_if.byte_data  = fifo_rdata[7:0];
   assign byte_if.byte_last  = fifo_rdata[8];

endmodule
